conv2d_sequencer: RTL and testbench
===================================

CONV2D_SEQUENCER -- requirements
Module: conv2d_sequencer

Interface
REQ-001 SHALL have parameter IMG_N, default 3: image side length in pixels; the image is IMG_N x IMG_N.
REQ-002 SHALL have parameter KER_K, default 2: kernel side length; KER_K <= IMG_N.
REQ-003 SHALL derive localparams M = IMG_N-KER_K+1, IA_W = max(1,clog2(IMG_N^2)), KA_W = max(1,clog2(KER_K^2)), RI_W = max(1,clog2(M^2)).
REQ-004 SHALL have ports clk (in, 1, single clock, rising edge) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-005 SHALL have port start (in, 1): begin a full-image convolution pass.
REQ-006 SHALL have ports busy (out, 1) and done (out, 1): done is a one-cycle pulse at the end of a pass.
REQ-007 SHALL have image read ports img_rd_en (out, 1), img_addr (out, IA_W) and img_rdata (in, 32): IEEE-754 single pixel, one-cycle synchronous read latency.
REQ-008 SHALL have kernel read ports ker_rd_en (out, 1), ker_addr (out, KA_W) and ker_rdata (in, 32): IEEE-754 single weight, one-cycle latency.
REQ-009 SHALL have datapath ports mac_a (out, 32), mac_b (out, 32), mac_valid (out, 1), mac_first (out, 1) and mac_last (out, 1): operand pair to the FP multiply-accumulate core.
REQ-010 SHALL have ports acc_valid (in, 1) and acc_data (in, 32): accumulated window sum returned by the core.
REQ-011 SHALL have result ports res_valid (out, 1), res_data (out, 32), res_index (out, RI_W) and res_ready (in, 1).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, WAIT_ACC, OUT and FIN.
REQ-013 In IDLE with start=1, SHALL clear the window row/column counters (wr, wc) and the tap counters (ti, tj), and enter RUN.
REQ-014 In IDLE, SHALL ignore start=0; in all states other than IDLE, SHALL ignore start.
REQ-015 In RUN, SHALL issue one tap per cycle, with img_rd_en=ker_rd_en=1, img_addr=(wr+ti)*IMG_N+(wc+tj) and ker_addr=ti*KER_K+tj.
REQ-016 SHALL advance taps row-major, incrementing tj and wrapping it at KER_K-1 with ti incremented.
REQ-017 After tap (KER_K-1, KER_K-1), SHALL move from RUN to WAIT_ACC.
REQ-018 SHALL assert mac_valid exactly one cycle after each read.
REQ-019 SHALL drive mac_a=img_rdata and mac_b=ker_rdata combinationally during that cycle.
REQ-020 SHALL set mac_first=1 only with tap (0,0) and mac_last=1 only with tap (K-1,K-1); mac_first and mac_last are 0 whenever mac_valid=0.
REQ-021 In WAIT_ACC, SHALL sample acc_valid, starting from the cycle that carries mac_last.
REQ-022 On acc_valid=1 in WAIT_ACC, SHALL register acc_data into res_data and move to OUT.
REQ-023 SHALL ignore acc_valid outside WAIT_ACC.
REQ-024 SHALL place no timeout on WAIT_ACC.
REQ-025 In OUT, SHALL hold res_valid=1 with res_data and res_index=wr*M+wc stable until res_ready=1 is seen on a rising edge.
REQ-026 On the OUT handshake, if (wr,wc)=(M-1,M-1), SHALL move to FIN.
REQ-027 On the OUT handshake otherwise, SHALL advance wc, wrapping it to 0 with wr+1, clear ti/tj and return to RUN.
REQ-028 FIN SHALL last one cycle with done=1 and then return to IDLE.
REQ-029 busy SHALL be 1 in RUN, WAIT_ACC, OUT and FIN, and 0 in IDLE.
REQ-030 SHALL use only the registered window/tap counters for all addresses, never arithmetic on the data.
REQ-031 SHALL pass 32-bit data through unmodified, with no floating-point arithmetic in this block.
REQ-032 With res_ready and acc_valid tied high and a core returning acc_valid the cycle after mac_last, each window SHALL take exactly KER_K^2+3 cycles from its first RUN cycle to its handshake.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE and clear all counters, in any state.
REQ-034 rst=1 at a rising edge SHALL force busy, done, img_rd_en, ker_rd_en, mac_valid, mac_first, mac_last and res_valid to 0.
REQ-035 rst=1 at a rising edge SHALL force img_addr, ker_addr, res_data and res_index to 0.
REQ-036 SHALL discard a read in flight when reset is applied: no mac_valid follows it.
REQ-037 After reset, SHALL start no pass until a new start is received.

Verification
REQ-038 SHALL cover, with IMG_N=3, KER_K=2: start -> window 0 img_addr 0,1,3,4 with ker_addr 0,1,2,3; window 3 img_addr 4,5,7,8; res_index sequence 0,1,2,3; exactly 4 results; one done pulse.
REQ-039 SHALL cover a model core returning acc_data = sum of a*b for pixels 1.2, -2.5, 3.4, ... (0x3F99999A, 0xC0200000, 0x4059999A) -> res_data equal to the model output bit-exact, pass-through only.
REQ-040 SHALL cover res_ready held low 5 cycles during OUT -> res_valid, res_data and res_index constant, no new reads issued, and the pass resumes on the cycle after the handshake.
REQ-041 SHALL cover start pulsed again during RUN of window 1 -> no effect; still exactly 4 results and one done.
REQ-042 SHALL cover rst=1 for one cycle during WAIT_ACC of window 2 -> all outputs 0 next cycle, a late acc_valid is ignored, and a fresh start reproduces the window 0 address sequence.
REQ-043 SHALL cover ideal handshakes -> 7 cycles per window and done asserted 28 cycles after the first RUN cycle.

Source files
------------

// File: rtl/conv2d_sequencer.sv
// conv2d_sequencer: walks every KER_K x KER_K window of an IMG_N x IMG_N image, streams
// pixel/weight pairs to an external FP MAC core and returns one accumulated sum per window.
module conv2d_sequencer #(
  parameter int IMG_N = 3,
  parameter int KER_K = 2,
  localparam int M    = IMG_N - KER_K + 1,
  localparam int IA_W = (IMG_N * IMG_N > 1) ? $clog2(IMG_N * IMG_N) : 1,
  localparam int KA_W = (KER_K * KER_K > 1) ? $clog2(KER_K * KER_K) : 1,
  localparam int RI_W = (M * M > 1) ? $clog2(M * M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            img_rd_en,
  output logic [IA_W-1:0] img_addr,
  input  logic [31:0]     img_rdata,
  output logic            ker_rd_en,
  output logic [KA_W-1:0] ker_addr,
  input  logic [31:0]     ker_rdata,
  output logic [31:0]     mac_a,
  output logic [31:0]     mac_b,
  output logic            mac_valid,
  output logic            mac_first,
  output logic            mac_last,
  input  logic            acc_valid,
  input  logic [31:0]     acc_data,
  output logic            res_valid,
  output logic [31:0]     res_data,
  output logic [RI_W-1:0] res_index,
  input  logic            res_ready
);

  localparam int CW = $clog2(IMG_N + 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] K_LAST = CW'(KER_K - 1);
  localparam logic [CW-1:0] M_LAST = CW'(M - 1);
  localparam logic [31:0]   N32    = 32'(IMG_N);
  localparam logic [31:0]   K32    = 32'(KER_K);
  localparam logic [31:0]   M32    = 32'(M);

  typedef enum logic [2:0] {IDLE, RUN, WAIT_ACC, OUT, FIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wr_q, wr_d, wc_q, wc_d;
  logic [CW-1:0] ti_q, ti_d, tj_q, tj_d;
  logic          rd_q, rd_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic [31:0]   res_data_q, res_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      wc_q       <= '0;
      ti_q       <= '0;
      tj_q       <= '0;
      rd_q       <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      wc_q       <= wc_d;
      ti_q       <= ti_d;
      tj_q       <= tj_d;
      rd_q       <= rd_d;
      first_q    <= first_d;
      last_q     <= last_d;
      res_data_q <= res_data_d;
    end
  end

  // rd/first/last are delayed one cycle so they line up with the memories' read data.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    ti_d       = ti_q;
    tj_d       = tj_q;
    rd_d       = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    res_data_d = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_d    = '0;
          wc_d    = '0;
          ti_d    = '0;
          tj_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rd_d    = 1'b1;
        first_d = (ti_q == '0) && (tj_q == '0);
        last_d  = (ti_q == K_LAST) && (tj_q == K_LAST);
        if (tj_q == K_LAST) begin
          tj_d = '0;
          if (ti_q == K_LAST) begin
            ti_d    = '0;
            state_d = WAIT_ACC;
          end else begin
            ti_d = ti_q + ONE;
          end
        end else begin
          tj_d = tj_q + ONE;
        end
      end
      WAIT_ACC: begin
        if (acc_valid) begin
          res_data_d = acc_data;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          if ((wr_q == M_LAST) && (wc_q == M_LAST)) begin
            state_d = FIN;
          end else begin
            ti_d    = '0;
            tj_d    = '0;
            state_d = RUN;
            if (wc_q == M_LAST) begin
              wc_d = '0;
              wr_d = wr_q + ONE;
            end else begin
              wc_d = wc_q + ONE;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses come purely from the registered counters and read as zero outside their state.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    img_rd_en = (state_q == RUN);
    ker_rd_en = (state_q == RUN);
    img_addr  = '0;
    ker_addr  = '0;
    res_valid = (state_q == OUT);
    res_index = '0;
    if (state_q == RUN) begin
      img_addr = IA_W'((32'(wr_q) + 32'(ti_q)) * N32 + 32'(wc_q) + 32'(tj_q));
      ker_addr = KA_W'(32'(ti_q) * K32 + 32'(tj_q));
    end
    if (state_q == OUT) begin
      res_index = RI_W'(32'(wr_q) * M32 + 32'(wc_q));
    end
  end

  assign mac_a     = img_rdata;
  assign mac_b     = ker_rdata;
  assign mac_valid = rd_q;
  assign mac_first = first_q;
  assign mac_last  = last_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_conv2d_sequencer.sv
// Self-checking bench for conv2d_sequencer (3x3 image, 2x2 kernel) with behavioural
// image/kernel memories, a floating-point MAC core model and a window-level reference.
module tb_conv2d_sequencer;

  localparam int N  = 3;
  localparam int K  = 2;
  localparam int M  = N - K + 1;
  localparam int KK = K * K;
  localparam int NW = M * M;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic        img_rd_en, ker_rd_en;
  logic [3:0]  img_addr;
  logic [1:0]  ker_addr;
  logic [31:0] img_rdata = '0;
  logic [31:0] ker_rdata = '0;
  logic [31:0] mac_a, mac_b;
  logic        mac_valid, mac_first, mac_last;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_data = '0;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_index;
  logic        res_ready;

  always #5 clk = ~clk;

  conv2d_sequencer #(.IMG_N(N), .KER_K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
    .ker_rd_en(ker_rd_en), .ker_addr(ker_addr), .ker_rdata(ker_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid),
    .mac_first(mac_first), .mac_last(mac_last),
    .acc_valid(acc_valid), .acc_data(acc_data),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
    .res_ready(res_ready)
  );

  // Synchronous one-cycle-latency image and kernel memories.
  logic [31:0] img_mem [N*N];
  logic [31:0] ker_mem [KK];

  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= img_mem[img_addr];
    if (ker_rd_en) ker_rdata <= ker_mem[ker_addr];
  end

  // MAC core model: accumulates products, answers acc_delay cycles after the cycle following mac_last.
  real         acc_r = 0.0;
  real         core_sum;
  int          acc_delay = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_bits = '0;

  always_comb core_sum = (mac_first ? 0.0 : acc_r) + ($bitstoshortreal(mac_a) * $bitstoshortreal(mac_b));

  always @(posedge clk) begin
    acc_valid <= 1'b0;
    if (mac_valid) acc_r <= core_sum;
    if (mac_valid && mac_last) begin
      if (acc_delay == 0) begin
        acc_valid <= 1'b1;
        acc_data  <= $shortrealtobits(core_sum);
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= acc_delay - 1;
        pend_bits <= $shortrealtobits(core_sum);
      end
    end else if (pend) begin
      if (pend_cnt == 0) begin
        acc_valid <= 1'b1;
        acc_data  <= pend_bits;
        pend      <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  typedef struct {
    int win;
    int tap;
    int exp_img;
    int exp_ker;
  } addr_vec_t;

  addr_vec_t vt [8];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int          rd_img_q [$];
  int          rd_ker_q [$];
  int          rd_cyc_q [$];
  int          res_idx_q [$];
  logic [31:0] res_dat_q [$];
  int          res_cyc_q [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cnt = 0;

  bit          exp_mv = 1'b0;
  int          prev_ia = 0;
  int          prev_ka = 0;
  int          prev_tap = 0;
  int          tap_n = 0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  int          hold_i = 0;
  bit          after_hs = 1'b0;
  bit          after_last = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  // Per-cycle protocol checks and event recording, sampled at the falling edge.
  task automatic monitor();
    if (mon_en) begin
      checkBit("mac_valid", mac_valid, exp_mv);
      checkBit("rd_en_pair", ker_rd_en, img_rd_en);
      if (exp_mv) begin
        checkOutput("mac_a", mac_a, img_mem[prev_ia]);
        checkOutput("mac_b", mac_b, ker_mem[prev_ka]);
        checkBit("mac_first", mac_first, prev_tap == 0);
        checkBit("mac_last", mac_last, prev_tap == KK - 1);
      end else begin
        checkBit("mac_first_idle", mac_first, 1'b0);
        checkBit("mac_last_idle", mac_last, 1'b0);
      end
      if (hold_v) begin
        checkBit("hold_valid", res_valid, 1'b1);
        checkOutput("hold_data", res_data, hold_d);
        checkOutput("hold_index", 32'(res_index), hold_i);
        checkBit("hold_no_read", img_rd_en, 1'b0);
      end
      if (after_hs) begin
        if (after_last) checkBit("fin_done", done, 1'b1);
        else checkBit("resume_read", img_rd_en, 1'b1);
      end
    end
    if (img_rd_en) begin
      rd_img_q.push_back(int'(img_addr));
      rd_ker_q.push_back(int'(ker_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (acc_valid) acc_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (res_valid && res_ready && !rst) begin
      res_idx_q.push_back(int'(res_index));
      res_dat_q.push_back(res_data);
      res_cyc_q.push_back(cyc);
    end
    exp_mv   = img_rd_en && !rst;
    prev_ia  = int'(img_addr);
    prev_ka  = int'(ker_addr);
    prev_tap = tap_n;
    if (rst) tap_n = 0;
    else if (img_rd_en) tap_n = (tap_n + 1) % KK;
    hold_v     = res_valid && !res_ready && !rst;
    hold_d     = res_data;
    hold_i     = int'(res_index);
    after_hs   = res_valid && res_ready && !rst;
    after_last = (int'(res_index) == NW - 1);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input bit rnd);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      if (rnd) res_ready = ($urandom_range(0, 2) != 0);
      tick();
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("[TB] FAIL pass_timeout: got no done want done within %0d cycles", budget);
    end
  endtask

  function automatic logic [31:0] expWin(input int w);
    int  wr = w / M;
    int  wc = w % M;
    real s = 0.0;
    for (int ti = 0; ti < K; ti++)
      for (int tj = 0; tj < K; tj++)
        s = s + $bitstoshortreal(img_mem[(wr + ti) * N + wc + tj]) * $bitstoshortreal(ker_mem[ti * K + tj]);
    return $shortrealtobits(s);
  endfunction

  task automatic checkResetState(input string tag);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_done"}, done, 1'b0);
    checkBit({tag, "_img_rd_en"}, img_rd_en, 1'b0);
    checkBit({tag, "_ker_rd_en"}, ker_rd_en, 1'b0);
    checkBit({tag, "_mac_valid"}, mac_valid, 1'b0);
    checkBit({tag, "_mac_first"}, mac_first, 1'b0);
    checkBit({tag, "_mac_last"}, mac_last, 1'b0);
    checkBit({tag, "_res_valid"}, res_valid, 1'b0);
    checkOutput({tag, "_img_addr"}, 32'(img_addr), 32'd0);
    checkOutput({tag, "_ker_addr"}, 32'(ker_addr), 32'd0);
    checkOutput({tag, "_res_data"}, res_data, 32'd0);
    checkOutput({tag, "_res_index"}, 32'(res_index), 32'd0);
  endtask

  // Whole-pass comparison against the window-level reference.
  task automatic checkPass(input int rb, input int sb, input int db, input string tag);
    checkOutput({tag, "_nreads"}, rd_img_q.size() - rb, NW * KK);
    for (int w = 0; w < NW; w++) begin
      for (int t = 0; t < KK; t++) begin
        int idx = rb + w * KK + t;
        int ea  = ((w / M) + t / K) * N + (w % M) + t % K;
        if (idx < rd_img_q.size()) begin
          checkOutput({tag, "_img_addr"}, rd_img_q[idx], ea);
          checkOutput({tag, "_ker_addr"}, rd_ker_q[idx], t);
        end
      end
    end
    checkOutput({tag, "_nresults"}, res_idx_q.size() - sb, NW);
    for (int w = 0; w < NW; w++) begin
      if (sb + w < res_idx_q.size()) begin
        checkOutput({tag, "_res_index"}, res_idx_q[sb + w], w);
        checkOutput({tag, "_res_data"}, res_dat_q[sb + w], expWin(w));
      end
    end
    checkOutput({tag, "_ndone"}, done_cnt - db, 1);
    checkBit({tag, "_idle_after"}, busy, 1'b0);
  endtask

  task automatic checkTable(input int rb, input bit win0_only, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (!win0_only || vt[i].win == 0) begin
        int idx = rb + vt[i].win * KK + vt[i].tap;
        checkOutput({tag, "_tbl_img"}, (idx < rd_img_q.size()) ? rd_img_q[idx] : -1, vt[i].exp_img);
        checkOutput({tag, "_tbl_ker"}, (idx < rd_ker_q.size()) ? rd_ker_q[idx] : -1, vt[i].exp_ker);
      end
    end
  endtask

  initial begin
    int rb, sb, db, c0, n, ml, ab;

    vt[0] = '{0, 0, 0, 0};
    vt[1] = '{0, 1, 1, 1};
    vt[2] = '{0, 2, 3, 2};
    vt[3] = '{0, 3, 4, 3};
    vt[4] = '{3, 0, 4, 0};
    vt[5] = '{3, 1, 5, 1};
    vt[6] = '{3, 2, 7, 2};
    vt[7] = '{3, 3, 8, 3};

    img_mem[0] = 32'h3F99999A;
    img_mem[1] = 32'hC0200000;
    img_mem[2] = 32'h4059999A;
    img_mem[3] = $shortrealtobits(0.75);
    img_mem[4] = $shortrealtobits(-1.5);
    img_mem[5] = $shortrealtobits(2.25);
    img_mem[6] = $shortrealtobits(4.0);
    img_mem[7] = $shortrealtobits(-0.125);
    img_mem[8] = $shortrealtobits(5.5);
    ker_mem[0] = $shortrealtobits(0.5);
    ker_mem[1] = $shortrealtobits(-1.0);
    ker_mem[2] = $shortrealtobits(2.0);
    ker_mem[3] = $shortrealtobits(0.25);

    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkResetState("reset");
    mon_en = 1'b1;
    repeat (3) tick();
    checkBit("idle_no_start", busy, 1'b0);

    // Ideal handshakes, with a stray start during window 1.
    rb = rd_img_q.size(); sb = res_idx_q.size(); db = done_cnt;
    applyStimulus();
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(200, 1'b0);
    repeat (6) tick();
    checkPass(rb, sb, db, "ideal");
    checkTable(rb, 1'b0, "ideal");
    c0 = (rb < rd_cyc_q.size()) ? rd_cyc_q[rb] : 0;
    for (int w = 0; w < NW; w++)
      checkOutput("ideal_win_cycle", (sb + w < res_cyc_q.size()) ? res_cyc_q[sb + w] - c0 : -1, 7 * w + 6);
    checkOutput("ideal_done_cycle", done_cyc - c0, 28);

    // Result stalled for five cycles in window 0.
    rb = rd_img_q.size(); sb = res_idx_q.size(); db = done_cnt;
    res_ready = 1'b0;
    applyStimulus();
    n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    checkBit("stall_reach_out", res_valid, 1'b1);
    repeat (5) tick();
    res_ready = 1'b1;
    waitDone(200, 1'b0);
    repeat (4) tick();
    checkPass(rb, sb, db, "stall");
    checkOutput("stall_hs_cycle",
                (sb < res_cyc_q.size() && rb < rd_cyc_q.size()) ? res_cyc_q[sb] - rd_cyc_q[rb] : -1, 11);

    // Randomised data, core latency and result back-pressure.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N * N; i++)
        img_mem[i] = $shortrealtobits((real'($urandom_range(0, 4000)) - 2000.0) / 128.0);
      for (int i = 0; i < KK; i++)
        ker_mem[i] = $shortrealtobits((real'($urandom_range(0, 4000)) - 2000.0) / 128.0);
      acc_delay = $urandom_range(0, 3);
      rb = rd_img_q.size(); sb = res_idx_q.size(); db = done_cnt;
      applyStimulus();
      waitDone(400, 1'b1);
      res_ready = 1'b1;
      repeat (4) tick();
      checkPass(rb, sb, db, "rand");
    end

    // Reset while a read is in flight.
    acc_delay = 0;
    applyStimulus();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("rst_run");
    tick();
    checkBit("rst_run_stays_idle", busy, 1'b0);

    // Reset during WAIT_ACC of window 2; the core's answer then arrives late.
    acc_delay = 4;
    applyStimulus();
    n = 0;
    ml = 0;
    while (ml < 3 && n < 100) begin
      tick();
      n++;
      if (mac_last) ml++;
    end
    checkOutput("rst_wait_reach", ml, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("rst_wait");
    ab = acc_cnt; sb = res_idx_q.size();
    repeat (10) tick();
    checkOutput("late_acc_seen", acc_cnt - ab, 1);
    checkBit("late_acc_busy", busy, 1'b0);
    checkBit("late_acc_res_valid", res_valid, 1'b0);
    checkOutput("late_acc_res_data", res_data, 32'd0);
    checkOutput("late_acc_nresults", res_idx_q.size() - sb, 0);

    // Fresh pass after reset reproduces the window 0 sequence.
    acc_delay = 0;
    rb = rd_img_q.size(); sb = res_idx_q.size(); db = done_cnt;
    applyStimulus();
    waitDone(200, 1'b0);
    repeat (4) tick();
    checkPass(rb, sb, db, "after_rst");
    checkTable(rb, 1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
